// File: rtl/calc_pkg.sv
// Calculator core button enumeration and hex-to-segment helper.
package calc_pkg;

    typedef enum logic [3:0] {
        BTN_0    = 4'd0,
        BTN_1    = 4'd1,
        BTN_2    = 4'd2,
        BTN_3    = 4'd3,
        BTN_4    = 4'd4,
        BTN_5    = 4'd5,
        BTN_6    = 4'd6,
        BTN_7    = 4'd7,
        BTN_8    = 4'd8,
        BTN_9    = 4'd9,
        BTN_ADD  = 4'd10,
        BTN_SUB  = 4'd11,
        BTN_EQ   = 4'd12,
        BTN_CLR  = 4'd13,
        BTN_NONE = 4'd15
    } active_button_t;

    // Segment pattern {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/nexys_pkg.sv
// Board-level constants and types shared by the Nexys 4 DDR calculator wrapper.
package nexys_pkg;

    localparam int CLK_FREQ_HZ  = 100_000_000;
    localparam int SLOW_FREQ_HZ = 1000;
    localparam int DIV_HALF     = CLK_FREQ_HZ / (2 * SLOW_FREQ_HZ);
    localparam int DIV_BITS     = 17;
    localparam int NUM_DIGITS   = 8;
    localparam int NUM_BUTTONS  = 14;

    // One byte per digit, {dp,g,f,e,d,c,b,a}, active-high, digit 0 rightmost.
    typedef logic [NUM_DIGITS-1:0][7:0] seg_vec_t;

endpackage

// File: rtl/calc_screen_driver.sv
// Converts the 32-bit display word into eight hex digits with leading zeros blanked.
module calc_screen_driver
    import calc_pkg::*;
(
    input  logic [31:0]      value_i,
    output logic [7:0][7:0]  display_segments_o
);

    logic lead;

    always_comb begin
        display_segments_o = '0;
        lead = 1'b1;
        // Scan from the most significant digit; digit 0 is always shown.
        for (int i = 7; i >= 1; i--) begin
            if (value_i[4*i +: 4] != 4'h0) lead = 1'b0;
            display_segments_o[i] = lead ? 8'h00 : {1'b0, hex_to_seg(value_i[4*i +: 4])};
        end
        display_segments_o[0] = {1'b0, hex_to_seg(value_i[3:0])};
    end

endmodule

// File: rtl/calculator.sv
// Hex accumulator calculator: digits shift into the entry, + - = C act on press.
module calculator
    import calc_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [13:0]      buttons_i,
    output logic [7:0][7:0]  display_segments_o
);

    active_button_t active_button;
    active_button_t next_button;
    logic [31:0]    entry;
    logic [31:0]    acc;
    logic [31:0]    display_rdata;
    logic [31:0]    entry_shift;
    logic           press;

    // Lowest-index pressed button wins.
    always_comb begin
        next_button = BTN_NONE;
        for (int i = 13; i >= 0; i--) begin
            if (buttons_i[i]) next_button = active_button_t'(4'(i));
        end
    end

    assign press       = (next_button != BTN_NONE) && (next_button != active_button);
    assign entry_shift = {entry[27:0], 4'(next_button)};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_button <= BTN_NONE;
            entry         <= '0;
            acc           <= '0;
            display_rdata <= '0;
        end else begin
            active_button <= next_button;
            if (press) begin
                case (next_button)
                    BTN_ADD: begin
                        acc           <= acc + entry;
                        display_rdata <= acc + entry;
                        entry         <= '0;
                    end
                    BTN_SUB: begin
                        acc           <= acc - entry;
                        display_rdata <= acc - entry;
                        entry         <= '0;
                    end
                    BTN_EQ: begin
                        display_rdata <= acc;
                        entry         <= '0;
                    end
                    BTN_CLR: begin
                        acc           <= '0;
                        entry         <= '0;
                        display_rdata <= '0;
                    end
                    BTN_NONE: ;
                    default: begin
                        entry         <= entry_shift;
                        display_rdata <= entry_shift;
                    end
                endcase
            end
        end
    end

    calc_screen_driver screen_driver (
        .value_i            (display_rdata),
        .display_segments_o (display_segments_o)
    );

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexes eight digits onto a shared-cathode display; outputs are registered.
module sevenseg_scan
    import nexys_pkg::*;
#(
    parameter int SCAN_BITS = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  seg_vec_t              segments_i,
    output logic [NUM_DIGITS-1:0] an_no,
    output logic [6:0]            ca_no,
    output logic                  dp_no
);

    localparam int CW = SCAN_BITS + 3;

    logic [CW-1:0] scan_cnt;
    logic [2:0]    digit_idx;

    assign digit_idx = scan_cnt[CW-1:SCAN_BITS];

    // Drive registers sample the index one cycle late so anode and cathode switch together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scan_cnt <= '0;
            an_no    <= '1;
            ca_no    <= 7'h7F;
            dp_no    <= 1'b1;
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
            an_no    <= ~(NUM_DIGITS'(1) << digit_idx);
            ca_no    <= ~segments_i[digit_idx][6:0];
            dp_no    <= ~segments_i[digit_idx][7];
        end
    end

endmodule

// File: rtl/nexys_4_ddr.sv
// Nexys 4 DDR board top: switch sync, 1 kHz core clock, display scan.
// Define NEXYS_DEBOUNCE_EN to debounce buttons in the 1 kHz domain.
module nexys_4_ddr #(
    parameter int CLK_FREQ_HZ  = nexys_pkg::CLK_FREQ_HZ,
    parameter int SLOW_FREQ_HZ = nexys_pkg::SLOW_FREQ_HZ,
    parameter int SCAN_BITS    = 14
) (
    input  logic        clk100mhz_i,
    input  logic        rst_ni,
    input  logic [15:0] switches_i,
    output logic [15:0] leds_o,
    output logic [7:0]  an_no,
    output logic [6:0]  ca_no,
    output logic        dp_no
);

    import nexys_pkg::*;

    localparam int HALF = CLK_FREQ_HZ / (2 * SLOW_FREQ_HZ);

    logic [15:0]            sync_q1;
    logic [15:0]            sync_q2;
    logic [DIV_BITS-1:0]    div_cnt;
    logic                   clk1khz;
    logic [NUM_BUTTONS-1:0] core_buttons;
    seg_vec_t               core_segments;

    always_ff @(posedge clk100mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= switches_i;
            sync_q2 <= sync_q1;
        end
    end

    assign leds_o = sync_q2;

    // clk1khz toggles every HALF input cycles, so the first rise lands HALF cycles after reset.
    always_ff @(posedge clk100mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt <= '0;
            clk1khz <= 1'b0;
        end else if (div_cnt == DIV_BITS'(HALF - 1)) begin
            div_cnt <= '0;
            clk1khz <= ~clk1khz;
        end else begin
            div_cnt <= div_cnt + DIV_BITS'(1);
        end
    end

`ifdef NEXYS_DEBOUNCE_EN
    logic [NUM_BUTTONS-1:0] db_sample;
    logic [NUM_BUTTONS-1:0] db_stable;
    logic [NUM_BUTTONS-1:0] db_agree;

    assign db_agree = ~(sync_q2[NUM_BUTTONS-1:0] ^ db_sample);

    // A bit only moves once two consecutive slow samples agree.
    always_ff @(posedge clk1khz or negedge rst_ni) begin
        if (!rst_ni) begin
            db_sample <= '0;
            db_stable <= '0;
        end else begin
            db_sample <= sync_q2[NUM_BUTTONS-1:0];
            db_stable <= (db_stable & ~db_agree) | (sync_q2[NUM_BUTTONS-1:0] & db_agree);
        end
    end

    assign core_buttons = db_stable;
`else
    assign core_buttons = sync_q2[NUM_BUTTONS-1:0];
`endif

    calculator calculator (
        .clk_i              (clk1khz),
        .rst_ni             (rst_ni),
        .buttons_i          (core_buttons),
        .display_segments_o (core_segments)
    );

    sevenseg_scan #(
        .SCAN_BITS (SCAN_BITS)
    ) u_scan (
        .clk_i      (clk100mhz_i),
        .rst_ni     (rst_ni),
        .segments_i (core_segments),
        .an_no      (an_no),
        .ca_no      (ca_no),
        .dp_no      (dp_no)
    );

endmodule

// File: tb/tb_nexys_4_ddr.sv
// Directed and randomized bench for nexys_4_ddr, run with scaled-down clock ratios.
module tb_nexys_4_ddr;

    localparam int CLK_HZ  = 100_000;
    localparam int SLOW_HZ = 1000;
    localparam int SB      = 4;
    localparam int HALF    = CLK_HZ / (2 * SLOW_HZ);
    localparam int SLOT    = 1 << SB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw = '0;
    logic [15:0] leds;
    logic [7:0]  an_n;
    logic [6:0]  ca_n;
    logic        dp_n;

    int n_checks = 0;
    int n_fail   = 0;
    int rise_q[$];
    int fall_q[$];
    logic [3:0] exp_q[$];

    // clock/reset block
    always #5 clk = ~clk;

    nexys_4_ddr #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .SLOW_FREQ_HZ (SLOW_HZ),
        .SCAN_BITS    (SB)
    ) dut (
        .clk100mhz_i (clk),
        .rst_ni      (rst_n),
        .switches_i  (sw),
        .leds_o      (leds),
        .an_no       (an_n),
        .ca_no       (ca_n),
        .dp_no       (dp_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_slow(input logic lvl, input string tag);
        int k = 0;
        while (dut.clk1khz !== lvl && k < 4 * HALF) begin
            step();
            k++;
        end
        if (dut.clk1khz !== lvl) check(tag, 32'(dut.clk1khz), 32'(lvl));
    endtask

    // Digit n cycles after reset release: slot index from the elapsed count, one cycle late.
    task automatic scan_model(input int n, output logic [7:0] an_e, output logic [6:0] ca_e);
        int idx;
        idx  = ((n - 1) / SLOT) % 8;
        an_e = 8'hFF;
        an_e[idx] = 1'b0;
        ca_e = (idx == 0) ? 7'h40 : 7'h7F;
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_an"}, an_n, 8'hFF);
        check({tag, "_ca"}, ca_n, 7'h7F);
        check({tag, "_dp"}, dp_n, 1'b1);
        check({tag, "_clk1khz"}, dut.clk1khz, 1'b0);
        check({tag, "_leds"}, leds, 16'h0000);
    endtask

    function automatic logic [3:0] lowest_button(input logic [15:0] v);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 14; i++) begin
            if (v[i]) begin
                r = 4'(i);
                break;
            end
        end
        return r;
    endfunction

    initial begin
        logic       prev;
        logic [7:0] an_e;
        logic [6:0] ca_e;
        int         k;
        int         n;

        // Reset held with switches active: everything stays blank.
        sw = 16'h3A5C;
        for (int i = 0; i < 125; i++) begin
            @(negedge clk);
            check_blank("reset_hold");
        end
        sw = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;

        // Divider timing and scan sequence from reset release.
        prev = 1'b0;
        for (int i = 1; i <= 11 * HALF + 2; i++) begin
            step();
            if (dut.clk1khz && !prev) rise_q.push_back(i);
            if (!dut.clk1khz && prev) fall_q.push_back(i);
            prev = dut.clk1khz;
            if (i <= 8 * SLOT + 2) begin
                scan_model(i, an_e, ca_e);
                check("scan_an", an_n, an_e);
                check("scan_ca", ca_n, ca_e);
                check("scan_dp", dp_n, 1'b1);
            end
        end
        check("rise_count_ok", 32'(rise_q.size() >= 5), 1);
        check("fall_count_ok", 32'(fall_q.size() >= 1), 1);
        if (rise_q.size() >= 5 && fall_q.size() >= 1) begin
            check("first_rise", rise_q[0], HALF);
            check("first_fall", fall_q[0], 2 * HALF);
            for (int i = 1; i < 5; i++) check("period", rise_q[i] - rise_q[i-1], 2 * HALF);
        end

        // Synchronizer latency and the core picking up button 2.
        @(negedge clk);
        sw = 16'h0004;
        step();
        check("sync_lat1", leds, 16'h0000);
        step();
        check("sync_lat2", leds, 16'h0004);
        wait_slow(1'b0, "wait_fall_sync");
        wait_slow(1'b1, "wait_rise_sync");
        check("btn2_seen", dut.calculator.active_button, 4'd2);

        // Random buttons, checked at each falling edge of the slow clock.
        wait_slow(1'b0, "wait_fall_rand0");
        for (int it = 0; it < 200; it++) begin
            sw = '0;
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) sw[$urandom_range(0, 13)] = 1'b1;
            sw[15:14] = 2'($urandom_range(0, 3));
            exp_q.push_back(lowest_button(sw));
            wait_slow(1'b1, "wait_rise_rand");
            wait_slow(1'b0, "wait_fall_rand");
            check("rand_active_button", dut.calculator.active_button, exp_q.pop_front());
            check("rand_leds", leds, sw);
            check("rand_no_x_out", 32'($isunknown({an_n, ca_n, dp_n, leds})), 0);
            check("rand_no_x_seg", 32'($isunknown(dut.core_segments)), 0);
        end

        // Asynchronous reset pulse in the middle of a cycle.
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_blank("async_rst");
        check("async_rst_div", dut.div_cnt, 0);
        check("async_rst_btn", dut.calculator.active_button, 4'hF);
        sw = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (dut.clk1khz !== 1'b1 && n < 4 * HALF) begin
            step();
            n++;
            if (n == 1) begin
                check("restart_an", an_n, 8'hFE);
                check("restart_ca", ca_n, 7'h40);
            end
        end
        check("restart_rise", n, HALF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nexys_4_ddr.md
Name: nexys_4_ddr

Overview:
- Board-level top for the calculator on the Digilent Nexys 4 DDR.
- Synchronizes the 16 slide switches and presents switches[13:0] as the 14 calculator buttons.
- Derives a 1 kHz 50%-duty internal clock (clk1khz) from the 100 MHz board clock and runs the existing `calculator` core on it.
- Time-multiplexes the core's 8-digit segment image onto the board's shared-cathode seven-segment display.

Parameters:
- CLK_FREQ_HZ, 100000000, input clock frequency.
- SLOW_FREQ_HZ, 1000, calculator clock frequency; half-period = CLK_FREQ_HZ/(2*SLOW_FREQ_HZ) = 50000 cycles.
- SCAN_BITS, 14, log2 of clk100mhz_i cycles per display digit slot.

Ports:
- clk100mhz_i  input  1  board clock, 100 MHz; the only clock port.
- rst_ni  input  1  asynchronous, active-low reset (CPU_RESETN button).
- switches_i  input  16  slide switches; [13:0] = buttons, [15:14] unused by the core.
- leds_o  output  16  synchronized switch echo.
- an_no  output  8  digit anodes, active-low, one-hot-low.
- ca_no  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
- dp_no  output  1  decimal point, active-low.

Behaviour:
- Reset: rst_ni is applied asynchronously to every flop, including the calculator core.
- Outputs in reset:
  - leds_o = 0.
  - an_no = 8'hFF (all digits off).
  - ca_no = 7'h7F.
  - dp_no = 1.
  - clk1khz = 0.
  - Divider counter = 0.
  - Scan counter = 0.
- Input sync: each switches_i bit passes through a 2-flop synchronizer on clk100mhz_i. leds_o = synchronized value, so latency is 2 cycles.
- Divider:
  - 17-bit counter on clk100mhz_i counts 0..49999.
  - On terminal count the counter wraps to 0 and clk1khz toggles.
  - Period is exactly 100000 clk100mhz_i cycles; the first rising edge occurs 50000 cycles after reset release.
- Core:
  - Instance name `calculator`, clocked by clk1khz, reset by rst_ni.
  - buttons_i = synchronized switches[13:0].
  - Core-internal names used by benches: active_button (calc_pkg::active_button_t), display_rdata, screen_driver.display_segments_o (8 digits × 8 bits {dp,g..a}, active-high, digit 0 rightmost).
  - Zero buttons: no action.
  - Two simultaneous buttons: the core's priority rule applies (lowest index wins). The wrapper passes all 14 bits unmodified.
- Scanner:
  - Free-running counter on clk100mhz_i; digit index = counter[SCAN_BITS+2:SCAN_BITS].
  - an_no[idx] = 0 and all other anodes = 1.
  - ca_no = ~seg[idx][6:0]; dp_no = ~seg[idx][7].
  - Segment data is registered once on clk100mhz_i, so outputs lag the index by 1 cycle, which is glitch-free.
  - Wraps 7→0.
- Reset mid-operation: all counters restart from 0 and the display blanks immediately (asynchronous).

Optional Feature:
- Macro NEXYS_DEBOUNCE_EN.
- Defined: each synchronized button bit is debounced in the clk1khz domain. A change is forwarded to the core only after 2 consecutive identical clk1khz samples, adding 1 clk1khz cycle of latency. leds_o stays undebounced.
- Undefined: synchronized bits connect directly to the core.

Decomposition:
- Package `nexys_pkg`: CLK_FREQ_HZ, SLOW_FREQ_HZ, DIV_HALF (50000), NUM_DIGITS (8), NUM_BUTTONS (14), and the segment-vector typedef (logic [7:0] per digit, packed array of 8).
- Button enumerations remain in calc_pkg.
- One sub-module: `sevenseg_scan` (scan counter, anode/cathode drive).
- Divider and synchronizers stay inline.

Test Plan:
- Reset: hold rst_ni=0 for 125000 clk100mhz_i cycles → an_no=8'hFF, ca_no=7'h7F, dp_no=1, clk1khz=0, leds_o=0 throughout.
- Divider: release reset → first clk1khz rise at cycle 50000, fall at 100000, and 100000-cycle period over 500 periods (total < 1.1e8 time units at 1-unit half-period).
- Sync: switches_i=16'h0004 → leds_o=16'h0004 exactly 2 clk100mhz_i cycles later; core sees button 2 at next clk1khz rise.
- Scan: force core segments digit0=8'h3F ("0"), others 0 → when counter[16:14]=0, an_no=8'hFE, ca_no=7'h40, dp_no=1; next slot an_no=8'hFD, ca_no=7'h7F.
- Random: 500 clk1khz iterations of 0/1/2 random buttons from [13:0] with a segment dump each negedge clk1khz → no X on outputs, and active_button matches the lowest set bit.
- Async reset pulse mid-scan → an_no=8'hFF within the same cycle; divider restarts, with next clk1khz rise 50000 cycles after release.
